// File: rtl/bp_me_lce_req_flit_scheduler_pkg.sv
// Shared definitions for the LCE request flit scheduler.
//   - bp_me_flit_sched_state_e : scheduler FSM state encoding
//   - ceil_div                 : flits needed to carry a packet
//   - len_lsb                  : bit position of the len field in a
//                                concentrator packet {payload, len, cid, cord}
package bp_me_lce_req_flit_scheduler_pkg;

    typedef enum logic [0:0] {
        e_idle = 1'b0,
        e_send = 1'b1
    } bp_me_flit_sched_state_e;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // cord sits at bit 0, cid directly above it, len directly above cid.
    function automatic int len_lsb(input int cord_w, input int cid_w);
        return cord_w + cid_w;
    endfunction

endpackage

// File: rtl/bp_me_lce_req_flit_scheduler_if.sv
// Bundle of the source-side and link-side signals of the flit scheduler.
//   packet_i         : num_req_p encoded packets, source k at slice k
//   v_i              : per-source packet valid
//   ready_and_o      : per-source ack, one-cycle pulse on last flit accept
//   link_data_o      : current flit
//   link_v_o         : flit valid
//   link_ready_and_i : link accepts the flit
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Valid never depends combinationally on ready. A source whose
// v_i is granted must keep v_i high and packet_i stable until its
// ready_and_o pulse; the pulse marks the cycle its last flit is accepted.
interface bp_me_lce_req_flit_scheduler_if #(
    parameter int num_req_p      = 2,
    parameter int packet_width_p = 256,
    parameter int flit_width_p   = 64
);
    logic [num_req_p*packet_width_p-1:0] packet_i;
    logic [num_req_p-1:0]                v_i;
    logic [num_req_p-1:0]                ready_and_o;
    logic [flit_width_p-1:0]             link_data_o;
    logic                                link_v_o;
    logic                                link_ready_and_i;

    // Scheduler side.
    modport master (
        input  packet_i, v_i, link_ready_and_i,
        output ready_and_o, link_data_o, link_v_o
    );

    // Sources + link side.
    modport slave (
        output packet_i, v_i, link_ready_and_i,
        input  ready_and_o, link_data_o, link_v_o
    );
endinterface

// File: rtl/bp_me_lce_req_flit_scheduler_arb.sv
// Round-robin arbiter for the flit scheduler.
//   clk_i, reset_n_i : clock, synchronous active-low reset
//   grants_en_i      : allow a grant this cycle
//   reqs_i           : per-source requests
//   yumi_i           : granted packet fully consumed this cycle
//   yumi_idx_i       : index of the consumed source
//   v_o              : a grant is offered
//   sel_o            : first requester at or above the pointer, with wrap
// The pointer moves to one past the consumed source, so that source goes
// to the back of the line.
module bp_me_lce_req_flit_scheduler_arb #(
    parameter int num_req_p = 2
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         grants_en_i,
    input  logic [num_req_p-1:0]         reqs_i,
    input  logic                         yumi_i,
    input  logic [$clog2(num_req_p)-1:0] yumi_idx_i,
    output logic                         v_o,
    output logic [$clog2(num_req_p)-1:0] sel_o
);
    localparam int sel_width_lp = $clog2(num_req_p);

    logic [sel_width_lp-1:0] rr_ptr_r;

    function automatic logic [sel_width_lp-1:0] wrap_idx(input int base, input int off);
        int j;
        j = base + off;
        if (j >= num_req_p) j = j - num_req_p;
        return sel_width_lp'(j);
    endfunction

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        sel_o = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            if (reqs_i[wrap_idx(int'(rr_ptr_r), i)]) sel_o = wrap_idx(int'(rr_ptr_r), i);
        end
        v_o = grants_en_i & (|reqs_i);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rr_ptr_r <= '0;
        end else if (yumi_i) begin
            rr_ptr_r <= wrap_idx(int'(yumi_idx_i), 1);
        end
    end
endmodule

// File: rtl/bp_me_lce_req_flit_scheduler.sv
// Shares one coherence-NoC request link among num_req_p LCE request
// sources. A valid source is picked round-robin, its grant is held for the
// whole packet, the packet goes out as len+1 flits, and the source gets a
// one-cycle ack with its last flit.
//   clk_i, reset_n_i : clock, synchronous active-low reset
//   bus              : packets/valids/acks and link flit handshake
//   dbg_state        : current FSM state
module bp_me_lce_req_flit_scheduler
    import bp_me_lce_req_flit_scheduler_pkg::*;
#(
    parameter int num_req_p      = 2,
    parameter int packet_width_p = 256,
    parameter int flit_width_p   = 64,
    parameter int cord_width_p   = 8,
    parameter int cid_width_p    = 2,
    parameter int len_width_p    = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    bp_me_lce_req_flit_scheduler_if.master bus,
    output bp_me_flit_sched_state_e       dbg_state
);
    localparam int max_flits_lp    = ceil_div(packet_width_p, flit_width_p);
    localparam int cnt_width_lp    = (max_flits_lp > 1) ? $clog2(max_flits_lp) : 1;
    localparam int sel_width_lp    = $clog2(num_req_p);
    localparam int len_lsb_lp      = len_lsb(cord_width_p, cid_width_p);
    localparam int padded_width_lp = max_flits_lp * flit_width_p;

    bp_me_flit_sched_state_e  state_r;
    logic [sel_width_lp-1:0]  sel_r;
    logic [cnt_width_lp-1:0]  len_r;
    logic [cnt_width_lp-1:0]  cnt_r;

    logic [packet_width_p-1:0]  src_packet [num_req_p];
    logic [padded_width_lp-1:0] padded;
    logic [len_width_p-1:0]     req_len;
    logic [cnt_width_lp-1:0]    len_sat;
    logic                       len_over;
    logic                       arb_v;
    logic [sel_width_lp-1:0]    arb_sel;
    logic                       hs;
    logic                       last_hs;

    for (genvar k = 0; k < num_req_p; k++) begin : g_unpack
        assign src_packet[k] = bus.packet_i[k*packet_width_p +: packet_width_p];
    end

    bp_me_lce_req_flit_scheduler_arb #(.num_req_p(num_req_p)) arb (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .grants_en_i(state_r == e_idle),
        .reqs_i     (bus.v_i),
        .yumi_i     (last_hs),
        .yumi_idx_i (sel_r),
        .v_o        (arb_v),
        .sel_o      (arb_sel)
    );

    // A len that would index past the last flit is clamped to the last flit.
    assign req_len  = src_packet[arb_sel][len_lsb_lp +: len_width_p];
    assign len_over = 32'(req_len) >= 32'(max_flits_lp);
    assign len_sat  = len_over ? cnt_width_lp'(max_flits_lp - 1) : cnt_width_lp'(req_len);

    assign hs       = (state_r == e_send) & bus.link_ready_and_i;
    assign last_hs  = hs & (cnt_r == len_r);

    assign bus.link_v_o = (state_r == e_send);
    assign dbg_state    = state_r;

    // Zero-pad the packet to a whole number of flits so the tail flit reads
    // zero above packet_width_p.
    always_comb begin
        padded = '0;
        padded[packet_width_p-1:0] = src_packet[sel_r];
        bus.link_data_o = '0;
        if (state_r == e_send) begin
            bus.link_data_o = padded[int'(cnt_r)*flit_width_p +: flit_width_p];
        end
    end

    always_comb begin
        bus.ready_and_o = '0;
        if (last_hs) bus.ready_and_o[sel_r] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r <= e_idle;
            sel_r   <= '0;
            len_r   <= '0;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                e_idle: begin
                    if (arb_v) begin
                        len_fits: assert (!len_over)
                            else $warning("len %0d from source %0d clamped to %0d flits",
                                          req_len, arb_sel, max_flits_lp);
                        sel_r   <= arb_sel;
                        len_r   <= len_sat;
                        cnt_r   <= '0;
                        state_r <= e_send;
                    end
                end
                e_send: begin
                    if (hs) begin
                        if (cnt_r == len_r) state_r <= e_idle;
                        else                cnt_r   <= cnt_r + cnt_width_lp'(1);
                    end
                end
                default: state_r <= e_idle;
            endcase
        end
    end

    // Granted source must hold its request and its packet until acked.
    granted_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (state_r == e_send) |-> bus.v_i[sel_r]);
    granted_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (state_r == e_send && !last_hs) |=> $stable(src_packet[sel_r]));
endmodule
